// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: glyph patterns and
// segment bit positions. Patterns are active-high with segment a in bit 0.
package seg7_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DP_BIT = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    localparam logic [SEG_W-1:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph (active-high, a = bit 0).
// Polarity is applied by the parent.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       i_nibble,
    output logic [SEG_W-1:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0: o_seg = SEG_GLYPH_0;
            4'h1: o_seg = SEG_GLYPH_1;
            4'h2: o_seg = SEG_GLYPH_2;
            4'h3: o_seg = SEG_GLYPH_3;
            4'h4: o_seg = SEG_GLYPH_4;
            4'h5: o_seg = SEG_GLYPH_5;
            4'h6: o_seg = SEG_GLYPH_6;
            4'h7: o_seg = SEG_GLYPH_7;
            4'h8: o_seg = SEG_GLYPH_8;
            4'h9: o_seg = SEG_GLYPH_9;
            4'hA: o_seg = SEG_GLYPH_A;
            4'hB: o_seg = SEG_GLYPH_B;
            4'hC: o_seg = SEG_GLYPH_C;
            4'hD: o_seg = SEG_GLYPH_D;
            4'hE: o_seg = SEG_GLYPH_E;
            4'hF: o_seg = SEG_GLYPH_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment controller with frame-aligned
// shadow loading, blanking, decimal points, leading-zero suppression and PWM.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned SCAN_DIV       = 100000,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lzs_en,
    input  logic [3:0]              bright,
    input  logic                    load,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int unsigned DATA_W   = 4 * NUM_DIGITS;
    localparam int unsigned SLOT_DIV = SCAN_DIV / 16;
    localparam int unsigned SUB_W    = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'(SLOT_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_INACT  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [7:0]            SEG_INACT = {8{SEG_ACTIVE_LOW}};

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
            $error("seg7_scan_ctrl: NUM_DIGITS must be 1..16");
        end
        if (SCAN_DIV < 16 || (SCAN_DIV % 16) != 0) begin : g_bad_div
            $error("seg7_scan_ctrl: SCAN_DIV must be a multiple of 16, >= 16");
        end
    endgenerate

    // Prescaler held as {phase, sub}: phase is the PWM step within a slot
    logic [SUB_W-1:0]      r_sub;
    logic [3:0]            r_phase;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_frame_done;

    logic [DATA_W-1:0]     r_sh_value;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [NUM_DIGITS-1:0] r_sh_blank;
    logic                  r_pending;

    logic [DATA_W-1:0]     r_act_value;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [NUM_DIGITS-1:0] r_act_blank;

    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_sub_wrap;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [NUM_DIGITS-1:0] w_supp;
    logic [3:0]            w_nibble;
    logic [SEG_W-1:0]      w_glyph;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [7:0]            w_seg_pos;

    assign w_sub_wrap  = (r_sub == SUB_LAST);
    assign w_slot_end  = w_sub_wrap && (r_phase == 4'hF);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sub        <= '0;
            r_phase      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_sub        <= w_sub_wrap ? '0 : r_sub + SUB_W'(1);
            r_frame_done <= w_frame_end;
            if (w_sub_wrap) begin
                r_phase <= r_phase + 4'd1;
            end
            if (w_slot_end) begin
                r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Active set only moves at a frame boundary; a coincident load bypasses shadow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sh_value  <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_pending   <= 1'b0;
            r_act_value <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
        end else begin
            if (load) begin
                r_sh_value <= value;
                r_sh_dp    <= dp_mask;
                r_sh_blank <= blank_mask;
            end
            if (w_frame_end && load) begin
                r_act_value <= value;
                r_act_dp    <= dp_mask;
                r_act_blank <= blank_mask;
                r_pending   <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end else if (w_frame_end && r_pending) begin
                r_act_value <= r_sh_value;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_pending   <= 1'b0;
            end
        end
    end

    // Digit i>0 is suppressed when it and every higher nibble are zero
    always_comb begin
        logic zero_run;
        w_supp   = '0;
        zero_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            zero_run  = zero_run && (r_act_value[4*i +: 4] == 4'h0);
            w_supp[i] = lzs_en && zero_run;
        end
    end

    assign w_nibble = 4'(r_act_value >> {r_idx, 2'b00});
    assign w_onehot = NUM_DIGITS'(1) << r_idx;
    assign w_lit    = !r_act_blank[r_idx] && !w_supp[r_idx] && (r_phase <= bright);

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_seg_pos         = {1'b0, w_glyph};
        w_seg_pos[DP_BIT] = r_act_dp[r_idx];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_an  <= AN_INACT;
            r_seg <= SEG_INACT;
        end else if (w_lit) begin
            r_an  <= w_onehot ^ AN_INACT;
            r_seg <= w_seg_pos ^ SEG_INACT;
        end else begin
            r_an  <= AN_INACT;
            r_seg <= {1'b0, SEG_OFF} ^ SEG_INACT;
        end
    end

    assign SEG        = r_seg;
    assign AN         = r_an;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 16 clocks per slot, active-low pins.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        lzs_en;
    logic [3:0]  bright;
    logic        load;
    logic [7:0]  SEG;
    logic [3:0]  AN;
    logic        frame_done;
    logic        pending;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (16),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .lzs_en     (lzs_en),
        .bright     (bright),
        .load       (load),
        .SEG        (SEG),
        .AN         (AN),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int lit;
        clr        = 1'b0;
        value      = 16'h0000;
        dp_mask    = 4'b0000;
        blank_mask = 4'b0000;
        lzs_en     = 1'b0;
        bright     = 4'd15;
        load       = 1'b0;

        // 1: reset hold, release, anode walk, frame_done cadence
        #2 clr = 1'b1;
        tick();
        tick();
        chk("rst_an", 32'(AN), 32'hF);
        chk("rst_seg", 32'(SEG), 32'hFF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        clr = 1'b0;
        cyc = 0;
        goto(1);
        chk("walk_an_d0", 32'(AN), 32'hE);
        chk("walk_seg_d0", 32'(SEG), 32'hC0);
        goto(16);
        chk("walk_an_d0_end", 32'(AN), 32'hE);
        goto(17);
        chk("walk_an_d1", 32'(AN), 32'hD);
        goto(33);
        chk("walk_an_d2", 32'(AN), 32'hB);
        goto(49);
        chk("walk_an_d3", 32'(AN), 32'h7);
        goto(63);
        chk("fd_before", 32'(frame_done), 32'h0);
        goto(64);
        chk("fd_pulse", 32'(frame_done), 32'h1);
        chk("fd_an_d3", 32'(AN), 32'h7);
        goto(65);
        chk("fd_after", 32'(frame_done), 32'h0);
        chk("wrap_an_d0", 32'(AN), 32'hE);
        goto(128);
        chk("fd_pulse2", 32'(frame_done), 32'h1);

        // 2: mid-frame load waits for the boundary
        goto(140);
        value   = 16'h12AF;
        dp_mask = 4'b0100;
        load    = 1'b1;
        tick();
        load  = 1'b0;
        value = 16'h0000;
        chk("ld_pending", 32'(pending), 32'h1);
        goto(150);
        chk("ld_nochange_seg", 32'(SEG), 32'hC0);
        goto(191);
        chk("ld_pend_hold", 32'(pending), 32'h1);
        chk("ld_old_d3", 32'(SEG), 32'hC0);
        goto(192);
        chk("ld_pend_clr", 32'(pending), 32'h0);
        goto(193);
        chk("ld_d0_an", 32'(AN), 32'hE);
        chk("ld_d0_F", 32'(SEG), 32'h8E);
        goto(209);
        chk("ld_d1_A", 32'(SEG), 32'h88);
        goto(225);
        chk("ld_d2_an", 32'(AN), 32'hB);
        chk("ld_d2_2dp", 32'(SEG), 32'h24);
        goto(241);
        chk("ld_d3_1", 32'(SEG), 32'hF9);

        // 3: leading-zero suppression
        goto(250);
        lzs_en = 1'b1;
        value  = 16'h0030;
        load   = 1'b1;
        tick();
        load = 1'b0;
        goto(257);
        chk("lzs_d0_0", 32'(SEG), 32'hC0);
        chk("lzs_d0_an", 32'(AN), 32'hE);
        goto(273);
        chk("lzs_d1_3", 32'(SEG), 32'hB0);
        chk("lzs_d1_an", 32'(AN), 32'hD);
        goto(289);
        chk("lzs_d2_an", 32'(AN), 32'hF);
        chk("lzs_d2_nodp", 32'(SEG), 32'hFF);
        goto(305);
        chk("lzs_d3_an", 32'(AN), 32'hF);
        goto(310);
        value = 16'h0000;
        load  = 1'b1;
        tick();
        load = 1'b0;
        goto(321);
        chk("lzs0_d0_seg", 32'(SEG), 32'hC0);
        chk("lzs0_d0_an", 32'(AN), 32'hE);
        goto(337);
        chk("lzs0_d1_an", 32'(AN), 32'hF);
        goto(369);
        chk("lzs0_d3_an", 32'(AN), 32'hF);

        // 4: PWM brightness
        goto(384);
        lzs_en = 1'b0;
        bright = 4'd3;
        lit    = 0;
        repeat (16) begin
            tick();
            if (AN !== 4'hF) lit++;
            if (cyc == 388) chk("pwm3_last_on", 32'(AN), 32'hE);
            if (cyc == 389) chk("pwm3_first_off", 32'(SEG), 32'hFF);
        end
        chk("pwm3_lit_cycles", 32'(lit), 32'd4);
        bright = 4'd0;
        lit    = 0;
        repeat (16) begin
            tick();
            if (AN !== 4'hF) lit++;
            if (cyc == 401) chk("pwm0_on_an", 32'(AN), 32'hD);
        end
        chk("pwm0_lit_cycles", 32'(lit), 32'd1);
        bright = 4'd15;

        // 5: last load wins, then a load coincident with the boundary
        goto(460);
        value = 16'h1111;
        load  = 1'b1;
        tick();
        load = 1'b0;
        goto(470);
        value = 16'h2222;
        load  = 1'b1;
        tick();
        load = 1'b0;
        chk("dbl_pending", 32'(pending), 32'h1);
        goto(500);
        chk("dbl_old_d3", 32'(SEG), 32'hC0);
        goto(513);
        chk("dbl_d0_2", 32'(SEG), 32'hA4);
        goto(545);
        chk("dbl_d2_2dp", 32'(SEG), 32'h24);
        goto(575);
        value      = 16'h0005;
        blank_mask = 4'b0010;
        load       = 1'b1;
        tick();
        load = 1'b0;
        chk("coin_fd", 32'(frame_done), 32'h1);
        chk("coin_pending", 32'(pending), 32'h0);
        goto(577);
        chk("coin_pend_after", 32'(pending), 32'h0);
        chk("coin_d0_5", 32'(SEG), 32'h92);
        goto(593);
        chk("blank_d1_an", 32'(AN), 32'hF);
        chk("blank_d1_seg", 32'(SEG), 32'hFF);
        goto(609);
        chk("coin_d2_0dp", 32'(SEG), 32'h40);

        // 6: asynchronous clear mid-slot on digit 2
        goto(615);
        chk("pre_clr_an", 32'(AN), 32'hB);
        #2 clr = 1'b1;
        #1;
        chk("clr_async_an", 32'(AN), 32'hF);
        chk("clr_async_seg", 32'(SEG), 32'hFF);
        chk("clr_async_pend", 32'(pending), 32'h0);
        tick();
        clr = 1'b0;
        cyc = 0;
        goto(1);
        chk("rel_d0_an", 32'(AN), 32'hE);
        chk("rel_d0_seg", 32'(SEG), 32'hC0);
        goto(17);
        chk("rel_d1_an", 32'(AN), 32'hD);
        goto(33);
        chk("rel_d2_an", 32'(AN), 32'hB);
        chk("rel_d2_nodp", 32'(SEG), 32'hC0);
        goto(64);
        chk("rel_fd", 32'(frame_done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
